// File: rtl/lift_scan_ctrl_if.sv
// Hall-call request and car-status bundle shared by the call source (master)
// and the lift controller (slave).
interface lift_scan_ctrl_if #(
  parameter int NUM_FLOORS = 4
);
  localparam int FW = $clog2(NUM_FLOORS);

  logic                    req_valid;
  logic [FW-1:0]           req_floor;
  logic                    req_dir;
  logic                    req_err;
  logic [1:0]              dout;
  logic [FW-1:0]           cur_floor;
  logic                    door_open;
  logic                    done;
  logic [2*NUM_FLOORS-1:0] pending;

  modport master (
    output req_valid, req_floor, req_dir,
    input  req_err, dout, cur_floor, door_open, done, pending
  );

  modport slave (
    input  req_valid, req_floor, req_dir,
    output req_err, dout, cur_floor, door_open, done, pending
  );
endinterface

// File: rtl/lift_scan_ctrl.sv
// SCAN-order lift controller: latches hall calls and sweeps the car one way, then back.
// Define LIFT_DOOR_DWELL_EN to hold the doors for DWELL_CYCLES instead of a single cycle.
module lift_scan_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_CYCLES = 4,
  parameter int DWELL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  lift_scan_ctrl_if.slave  bus
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int PW = 2 * NUM_FLOORS;
  localparam int TW = $clog2(FLOOR_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(FLOOR_CYCLES - 1);
  localparam logic [PW-1:0] ONE         = PW'(1);
  localparam logic [FW-1:0] TOP         = FW'(NUM_FLOORS - 1);
  localparam logic [FW:0]   NF_EXT      = (FW + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] curFloor_q, curFloor_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [TW-1:0] travel_q, travel_d;
  logic          reqErr_q, reqErr_d;

  logic          reqBad, reqOk;
  logic [PW-1:0] setMask, clrMask, doorClr;
  logic [FW-1:0] nextFloor;
  logic          doorHold;

  function automatic logic [PW-1:0] floorMask(input logic [FW-1:0] f);
    return (ONE << f) | (ONE << (int'(f) + NUM_FLOORS));
  endfunction

  function automatic logic [PW-1:0] dirMask(input logic [FW-1:0] f, input logic d);
    return d ? (ONE << (int'(f) + NUM_FLOORS)) : (ONE << f);
  endfunction

  // True when any call (either direction) sits strictly beyond floor f in direction d.
  function automatic logic callsBeyond(input logic [PW-1:0] p, input logic [FW-1:0] f,
                                       input logic d);
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if ((d && i < int'(f)) || (!d && i > int'(f))) m = m | floorMask(FW'(i));
    end
    return (p & m) != '0;
  endfunction

  always_comb begin
    reqBad  = ({1'b0, bus.req_floor} >= NF_EXT)
           || (!bus.req_dir && bus.req_floor == TOP)
           || ( bus.req_dir && bus.req_floor == '0);
    reqOk   = bus.req_valid && !reqBad;
    setMask = reqOk ? dirMask(bus.req_floor, bus.req_dir) : '0;
  end

  assign nextFloor = dir_q ? curFloor_q - 1'b1 : curFloor_q + 1'b1;

`ifdef LIFT_DOOR_DWELL_EN
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic          reqAtCur;

  assign reqAtCur = reqOk && (bus.req_floor == curFloor_q);
  assign doorHold = reqAtCur || (dwell_q != '0);
  assign doorClr  = reqAtCur ? setMask : '0;

  // A fresh call at the open floor is absorbed and restarts the dwell period.
  always_comb begin
    dwell_d = dwell_q;
    if (state_q != DOOR) begin
      if (state_d == DOOR) dwell_d = DWELL_LOAD;
    end else if (reqAtCur) begin
      dwell_d = DWELL_LOAD;
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dwell_q <= '0;
    else     dwell_q <= dwell_d;
  end
`else
  assign doorHold = 1'b0;
  assign doorClr  = '0;

  // DWELL_CYCLES only shapes the design when the dwell timer is built.
  if (DWELL_CYCLES < 1) begin : gDwellRange
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      curFloor_q <= '0;
      dir_q      <= 1'b0;
      pending_q  <= '0;
      travel_q   <= '0;
      reqErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      curFloor_q <= curFloor_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      travel_q   <= travel_d;
      reqErr_q   <= reqErr_d;
    end
  end

  // Clearing is applied after setting so a call arriving as its floor is served is dropped.
  always_comb begin
    state_d    = state_q;
    curFloor_d = curFloor_q;
    dir_d      = dir_q;
    travel_d   = travel_q;
    clrMask    = '0;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          if ((pending_q & floorMask(curFloor_q)) != '0) begin
            clrMask = floorMask(curFloor_q);
            state_d = DOOR;
          end else begin
            if (!callsBeyond(pending_q, curFloor_q, dir_q)) dir_d = ~dir_q;
            travel_d = TRAVEL_LOAD;
            state_d  = MOVE;
          end
        end
      end
      MOVE: begin
        if (travel_q != '0) begin
          travel_d = travel_q - 1'b1;
        end else begin
          curFloor_d = nextFloor;
          if (!callsBeyond(pending_q, nextFloor, dir_q)) begin
            clrMask = floorMask(nextFloor);
            state_d = DOOR;
          end else if ((pending_q & dirMask(nextFloor, dir_q)) != '0) begin
            clrMask = dirMask(nextFloor, dir_q);
            state_d = DOOR;
          end else begin
            travel_d = TRAVEL_LOAD;
          end
        end
      end
      DOOR: begin
        clrMask = doorClr;
        if (!doorHold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | setMask) & ~clrMask;
    reqErr_d  = bus.req_valid && reqBad;
  end

  always_comb begin
    bus.dout      = (state_q == MOVE) ? {1'b0, dir_q} : 2'b10;
    bus.door_open = (state_q == DOOR);
    bus.done      = (state_q == IDLE) && (pending_q == '0);
  end

  assign bus.req_err   = reqErr_q;
  assign bus.cur_floor = curFloor_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Self-checking bench for lift_scan_ctrl: reset, idle call, clear-wins, door timing,
// mid-move reset, SCAN ordering, reversal and call rejection.
module tb_lift_scan_ctrl;

  localparam int NF = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lift_scan_ctrl_if #(.NUM_FLOORS(NF)) bus();
  lift_scan_ctrl_if #(.NUM_FLOORS(5))  bus5();

  lift_scan_ctrl #(.NUM_FLOORS(NF), .FLOOR_CYCLES(4), .DWELL_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lift_scan_ctrl #(.NUM_FLOORS(5), .FLOOR_CYCLES(4), .DWELL_CYCLES(3)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  typedef struct {
    logic [1:0] floor;
    logic       dir;
    logic       expErr;
    logic [7:0] expPending;
  } vec_t;

  int   nAssert = 0;
  int   nFail   = 0;
  int   upCycles = 0;
  int   downCycles = 0;
  int   stopQ[$];
  logic errQ[$];
  logic prevDoor = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle call strobe; the expected req_err is queued and compared once the DUT responds.
  task automatic applyStimulus(input logic [1:0] floor, input logic dir, input logic expErr);
    bus.req_valid = 1'b1;
    bus.req_floor = floor;
    bus.req_dir   = dir;
    errQ.push_back(expErr);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput($sformatf("req_err floor%0d dir%0d", floor, dir), 32'(bus.req_err),
                32'(errQ.pop_front()));
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (!bus.done && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle reached in budget", 32'(bus.done), 1);
  endtask

  // Motion cycle counters and stop-order scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dout == 2'b00) upCycles++;
      else if (bus.dout == 2'b01) downCycles++;
      if (bus.door_open && !prevDoor) begin
        if (stopQ.size() == 0) begin
          nAssert++;
          nFail++;
          $display("[TB] FAIL unexpected stop: at floor %0d, expected none", bus.cur_floor);
        end else begin
          checkOutput("stop floor", 32'(bus.cur_floor), stopQ.pop_front());
        end
      end
      prevDoor = bus.door_open;
    end
  end

  initial begin
    vec_t vecs[7];
    logic [2:0] f5[3];
    logic       d5[3];
    logic       e5[3];
    logic [9:0] p5[3];
    int upStart, downStart;

    bus.req_valid  = 1'b0;
    bus.req_floor  = '0;
    bus.req_dir    = 1'b0;
    bus5.req_valid = 1'b0;
    bus5.req_floor = '0;
    bus5.req_dir   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset dout", 32'(bus.dout), 2);
    checkOutput("reset cur_floor", 32'(bus.cur_floor), 0);
    checkOutput("reset door_open", 32'(bus.door_open), 0);
    checkOutput("reset done", 32'(bus.done), 1);
    checkOutput("reset pending", 32'(bus.pending), 0);
    checkOutput("reset req_err", 32'(bus.req_err), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] idle call up@2 from floor 0");
    upStart = upCycles;
    stopQ.push_back(2);
`ifndef LIFT_DOOR_DWELL_EN
    stopQ.push_back(2);
`endif
    applyStimulus(2'd2, 1'b0, 1'b0);
    checkOutput("up@2 latched", 32'(bus.pending), 32'h04);
    checkOutput("done drops", 32'(bus.done), 0);
    checkOutput("dout still STAY", 32'(bus.dout), 2);
    @(negedge clk);
    checkOutput("first UP", 32'(bus.dout), 0);
    repeat (7) @(negedge clk);
    checkOutput("passed floor 1", 32'(bus.cur_floor), 1);
    checkOutput("still UP", 32'(bus.dout), 0);
    applyStimulus(2'd2, 1'b1, 1'b0);
    checkOutput("arrived door_open", 32'(bus.door_open), 1);
    checkOutput("arrived cur_floor", 32'(bus.cur_floor), 2);
    checkOutput("clear wins pending", 32'(bus.pending), 0);
    applyStimulus(2'd2, 1'b0, 1'b0);
`ifdef LIFT_DOOR_DWELL_EN
    checkOutput("dwell restart door_open", 32'(bus.door_open), 1);
    checkOutput("dwell call absorbed", 32'(bus.pending), 0);
    repeat (2) @(negedge clk);
    checkOutput("dwell extended", 32'(bus.door_open), 1);
    @(negedge clk);
    checkOutput("dwell over", 32'(bus.door_open), 0);
    checkOutput("done after dwell", 32'(bus.done), 1);
`else
    checkOutput("1-cycle DOOR closed", 32'(bus.door_open), 0);
    checkOutput("door call latched", 32'(bus.pending), 32'h04);
    @(negedge clk);
    checkOutput("served from IDLE", 32'(bus.door_open), 1);
    checkOutput("served pending", 32'(bus.pending), 0);
    @(negedge clk);
    checkOutput("door closed again", 32'(bus.door_open), 0);
    checkOutput("done after DOOR", 32'(bus.done), 1);
`endif
    waitIdle(20);
    checkOutput("idle call UP cycles", upCycles - upStart, 8);
    checkOutput("idle call stops consumed", stopQ.size(), 0);

    $display("[TB] reset while moving");
    applyStimulus(2'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("moving DOWN", 32'(bus.dout), 1);
    checkOutput("still at 2", 32'(bus.cur_floor), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async dout", 32'(bus.dout), 2);
    checkOutput("async cur_floor", 32'(bus.cur_floor), 0);
    checkOutput("async pending", 32'(bus.pending), 0);
    checkOutput("async done", 32'(bus.done), 1);
    checkOutput("async door_open", 32'(bus.door_open), 0);
    checkOutput("async req_err", 32'(bus.req_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] rejection and SCAN table");
    vecs[0] = '{2'd3, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{2'd0, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{2'd1, 1'b0, 1'b0, 8'h02};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 8'h82};
    vecs[4] = '{2'd2, 1'b0, 1'b0, 8'h86};
    vecs[5] = '{2'd1, 1'b0, 1'b0, 8'h86};
    vecs[6] = '{2'd3, 1'b0, 1'b1, 8'h86};
    upStart   = upCycles;
    downStart = downCycles;
    stopQ.push_back(1);
    stopQ.push_back(2);
    stopQ.push_back(3);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].floor, vecs[i].dir, vecs[i].expErr);
      checkOutput($sformatf("vec%0d pending", i), 32'(bus.pending), 32'(vecs[i].expPending));
    end
    waitIdle(100);
    checkOutput("scan end floor", 32'(bus.cur_floor), 3);
    checkOutput("scan pending", 32'(bus.pending), 0);
    checkOutput("scan UP cycles", upCycles - upStart, 12);
    checkOutput("scan no reversal", downCycles - downStart, 0);
    checkOutput("scan stops consumed", stopQ.size(), 0);

    $display("[TB] reversal to up@0 from floor 3");
    upStart   = upCycles;
    downStart = downCycles;
    stopQ.push_back(0);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("up@0 latched", 32'(bus.pending), 32'h01);
    waitIdle(100);
    checkOutput("reversal floor", 32'(bus.cur_floor), 0);
    checkOutput("reversal DOWN cycles", downCycles - downStart, 12);
    checkOutput("reversal no UP", upCycles - upStart, 0);
    checkOutput("reversal stops consumed", stopQ.size(), 0);

    $display("[TB] out-of-range floor on 5-floor car");
    f5 = '{3'd5, 3'd4, 3'd4};
    d5 = '{1'b0, 1'b0, 1'b1};
    e5 = '{1'b1, 1'b1, 1'b0};
    p5 = '{10'h000, 10'h000, 10'h200};
    for (int i = 0; i < 3; i++) begin
      bus5.req_valid = 1'b1;
      bus5.req_floor = f5[i];
      bus5.req_dir   = d5[i];
      @(negedge clk);
      bus5.req_valid = 1'b0;
      checkOutput($sformatf("nf5 req_err row%0d", i), 32'(bus5.req_err), 32'(e5[i]));
      checkOutput($sformatf("nf5 pending row%0d", i), 32'(bus5.pending), 32'(p5[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
